// File: rtl/spi_register_bridge.sv
// ============================================================================
// Module   : spi_register_bridge
// Purpose  : Turns each completed SPI word into one register-bus read/write
//            with a strobe timeout, and captures the result as the next MISO word.
// Options  : SPI_REGISTER_BRIDGE_AUTOINC_EN - all-ones address selects an
//            auto-incrementing pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_register_bridge #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255,
  localparam int WIDTH     = 1 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  system_clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value_mosi,
  input  logic                  value_valid,
  input  logic                  cs_stop,
  output logic [WIDTH-1:0]      value_miso,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]        miso_q, miso_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_error_q, frame_error_d;
  logic [ADDR_WIDTH-1:0]   frame_addr;
  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic                    done;

  assign frame_addr = value_mosi[WIDTH-2:DATA_WIDTH];

`ifdef SPI_REGISTER_BRIDGE_AUTOINC_EN
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  assign eff_addr = (&frame_addr) ? ptr_q : frame_addr;

  // Pointer follows the address actually used, on success and timeout alike.
  always_comb begin
    ptr_d = ptr_q;
    if (done) ptr_d = addr_q + 1'b1;
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign eff_addr = frame_addr;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    miso_d        = miso_q;
    overrun_d     = 1'b0;
    frame_error_d = cs_stop & ~value_valid;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        if (value_valid) begin
          addr_d  = eff_addr;
          wdata_d = value_mosi[DATA_WIDTH-1:0];
          cnt_d   = '0;
          state_d = value_mosi[WIDTH-1] ? WRITE : READ;
        end
      end
      WRITE, READ: begin
        overrun_d = value_valid;
        // Ack is checked before the count so an ack in the last cycle succeeds.
        if (bus_ack) begin
          miso_d  = {1'b1, addr_q, (state_q == READ) ? bus_rdata : wdata_q};
          state_d = IDLE;
          done    = 1'b1;
        end else if (cnt_q == C_CNT_LAST) begin
          miso_d  = {1'b0, addr_q, {DATA_WIDTH{1'b0}}};
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      miso_q        <= '0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      miso_q        <= miso_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign value_miso  = miso_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_we      = (state_q == WRITE);
  assign bus_re      = (state_q == READ);
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_register_bridge.sv
// ============================================================================
// Module   : tb_spi_register_bridge
// Purpose  : Table-driven self-checking bench for spi_register_bridge
//            (TIMEOUT=8) with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_register_bridge;

  localparam int TO = 8;

  logic        system_clk = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] value_mosi = '0;
  logic        value_valid = 1'b0;
  logic        cs_stop = 1'b0;
  logic [20:0] value_miso;
  logic [3:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we, bus_re;
  logic [15:0] bus_rdata = 16'hDEAD;
  logic        bus_ack = 1'b0;
  logic        busy, overrun, frame_error;

  spi_register_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .TIMEOUT(TO)) dut (
    .system_clk (system_clk),
    .reset      (reset),
    .value_mosi (value_mosi),
    .value_valid(value_valid),
    .cs_stop    (cs_stop),
    .value_miso (value_miso),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .busy       (busy),
    .overrun    (overrun),
    .frame_error(frame_error)
  );

  always #5 system_clk = ~system_clk;

  typedef struct {
    logic [20:0] word;
    logic        cs;
    int          ack_at;
    logic [15:0] rdata;
    logic [20:0] exp_miso;
    int          exp_cycles;
  } vec_t;

  vec_t        tbl[7];
  logic [20:0] sb_q[$];
  logic [20:0] last_miso = '0;
  logic [3:0]  model_ptr = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; drives the frame immediately so consecutive
  // calls exercise back-to-back acceptance.
  task automatic do_frame(input vec_t v);
    logic [3:0]  ea;
    logic [20:0] exp;
    int          n;
    ea = v.word[19:16];
`ifdef SPI_REGISTER_BRIDGE_AUTOINC_EN
    if (ea == 4'hF) ea = model_ptr;
`endif
    exp = v.exp_miso;
    exp[19:16] = ea;
    sb_q.push_back(exp);
    value_mosi  = v.word;
    value_valid = 1'b1;
    cs_stop     = v.cs;
    @(negedge system_clk);
    value_valid = 1'b0;
    cs_stop     = 1'b0;
    check("busy_start", busy, 1);
    check("bus_addr", bus_addr, ea);
    check("bus_wdata", bus_wdata, v.word[15:0]);
    check("bus_we", bus_we, v.word[20]);
    check("bus_re", bus_re, !v.word[20]);
    check("no_frame_err", frame_error, 0);
    check("miso_hold", value_miso, last_miso);
    n = 0;
    while ((bus_we || bus_re) && n < TO + 5) begin
      n++;
      if (n == v.ack_at) begin
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
      end
      @(negedge system_clk);
      bus_ack   = 1'b0;
      bus_rdata = 16'hDEAD;
    end
    check("strobe_cycles", n, v.exp_cycles);
    check("busy_end", busy, 0);
    exp = sb_q.pop_front();
    check("value_miso", value_miso, exp);
    last_miso = exp;
    model_ptr = ea + 4'd1;
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{21'h13BEEF, 1'b0, 2, 16'h0000, 21'h13BEEF, 2};
    tbl[1] = '{21'h050000, 1'b0, 1, 16'h1234, 21'h151234, 1};
    tbl[2] = '{21'h050000, 1'b0, 0, 16'h0000, 21'h050000, TO};
    tbl[3] = '{21'h0A0000, 1'b0, TO, 16'hCAFE, 21'h1ACAFE, TO};
    tbl[4] = '{21'h1F5555, 1'b0, 3, 16'h0000, 21'h1F5555, 3};
    tbl[5] = '{21'h07FFFF, 1'b1, 4, 16'h0001, 21'h170001, 4};
    tbl[6] = '{21'h100000, 1'b0, 0, 16'h0000, 21'h000000, TO};

    #1;
    check("rst_miso", value_miso, 0);
    check("rst_we", bus_we, 0);
    check("rst_re", bus_re, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {overrun, frame_error}, 0);
    check("rst_addr_wdata", {bus_addr, bus_wdata}, 0);
    repeat (2) @(negedge system_clk);
    reset = 1'b0;
    @(negedge system_clk);

    for (int i = 0; i < 7; i++) do_frame(tbl[i]);

    // Late ack after a timeout must be ignored.
    @(negedge system_clk);
    v = '{21'h050000, 1'b0, 0, 16'h0000, 21'h050000, TO};
    do_frame(v);
    bus_ack = 1'b1;
    bus_rdata = 16'h7777;
    @(negedge system_clk);
    bus_ack = 1'b0;
    check("late_ack_re", {bus_we, bus_re, busy}, 0);
    check("late_ack_miso", value_miso, 21'h050000);

    // Overrun mid-operation and in the completion cycle.
    value_mosi = 21'h050000;
    value_valid = 1'b1;
    @(negedge system_clk);
    value_valid = 1'b0;
    @(negedge system_clk);
    value_mosi = 21'h13AAAA;
    value_valid = 1'b1;
    @(negedge system_clk);
    value_valid = 1'b0;
    check("overrun_pulse", overrun, 1);
    check("overrun_addr", bus_addr, 4'h5);
    check("overrun_wdata", bus_wdata, 16'h0000);
    check("overrun_strobe", {bus_we, bus_re}, 2'b01);
    @(negedge system_clk);
    check("overrun_clear", overrun, 0);
    bus_ack = 1'b1;
    bus_rdata = 16'h0042;
    value_valid = 1'b1;
    @(negedge system_clk);
    bus_ack = 1'b0;
    bus_rdata = 16'hDEAD;
    value_valid = 1'b0;
    check("overrun_done_cycle", overrun, 1);
    check("overrun_miso", value_miso, 21'h150042);
    @(negedge system_clk);
    check("overrun_dropped", {busy, bus_we, bus_re, overrun}, 0);
    last_miso = 21'h150042;
    model_ptr = 4'h6;

    // cs_stop with no word.
    cs_stop = 1'b1;
    @(negedge system_clk);
    cs_stop = 1'b0;
    check("frame_err_pulse", frame_error, 1);
    check("frame_err_idle", {busy, bus_we, bus_re}, 0);
    @(negedge system_clk);
    check("frame_err_clear", frame_error, 0);

    // Write 0xE then read 0xF (pointer target when auto-increment is on).
    v = '{21'h1E1111, 1'b0, 1, 16'h0000, 21'h1E1111, 1};
    do_frame(v);
    v = '{21'h0F0000, 1'b0, 1, 16'h5678, 21'h1F5678, 1};
    do_frame(v);

    // Reset in the middle of a read abandons it.
    @(negedge system_clk);
    value_mosi = 21'h020000;
    value_valid = 1'b1;
    @(negedge system_clk);
    value_valid = 1'b0;
    @(negedge system_clk);
    check("pre_reset_re", bus_re, 1);
    reset = 1'b1;
    #1;
    check("reset_re", bus_re, 0);
    check("reset_busy", busy, 0);
    check("reset_miso", value_miso, 0);
    @(negedge system_clk);
    reset = 1'b0;
    last_miso = '0;
    model_ptr = '0;
    @(negedge system_clk);
    v = '{21'h020000, 1'b0, 2, 16'h0BAD, 21'h120BAD, 2};
    do_frame(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/spi_register_bridge.md
Name: spi_register_bridge

Overview:
- Sits directly downstream of the SPI slave word interface.
- Decodes each completed SPI word into a single register-bus read or write, and drives a simple request/acknowledge bus.
- Captures the result into a response word. The SPI slave returns that word to the master during the next SPI transaction.
- Converts fixed-width SPI words into fabric register accesses with timeout protection.

Parameters:
- ADDR_WIDTH, 4, register-bus address width.
- DATA_WIDTH, 16, register-bus data width.
- TIMEOUT, 255, maximum system_clk cycles a bus strobe is held while waiting for bus_ack; must be ≥1.
- WIDTH, localparam = 1+ADDR_WIDTH+DATA_WIDTH, SPI word width; must match the SPI slave's WIDTH.

Ports:
- system_clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- value_mosi  in  WIDTH  word received from the master.
- value_valid  in  1  one-cycle pulse: value_mosi complete and valid.
- cs_stop  in  1  one-cycle pulse: chip-select deasserted.
- value_miso  out  WIDTH  response word offered to the SPI slave.
- bus_addr  out  ADDR_WIDTH  register address.
- bus_wdata  out  DATA_WIDTH  write data.
- bus_we  out  1  write request, level, held until ack or timeout.
- bus_re  out  1  read request, level, held until ack or timeout.
- bus_rdata  in  DATA_WIDTH  read data, valid in the cycle bus_ack is high.
- bus_ack  in  1  completes the pending request.
- busy  out  1  operation in progress.
- overrun  out  1  one-cycle pulse: frame dropped because busy.
- frame_error  out  1  one-cycle pulse: cs_stop without value_valid.

Behaviour:
- Frame layout, MSB first:
  - bit WIDTH-1: write flag (1 = write).
  - bits WIDTH-2..DATA_WIDTH: address.
  - bits DATA_WIDTH-1..0: data; ignored for reads.
- Response layout, same field positions:
  - bit WIDTH-1: ok (1 = acked, 0 = timed out).
  - address field: address of the last operation.
  - data field: read data, write data echoed, or 0 on timeout.
- Reset (asynchronous, immediate): state IDLE; bus_we = bus_re = 0; busy = 0; overrun = frame_error = 0; value_miso = 0; bus_addr = bus_wdata = 0; timeout counter = 0. An operation in progress is abandoned with no response update.
- FSM states: IDLE, WRITE, READ.
- IDLE, value_valid in cycle N:
  - latch address and data into bus_addr and bus_wdata;
  - clear the timeout counter;
  - go to WRITE if the write flag is 1, else READ.
  - bus_we or bus_re and busy are high from cycle N+1.
- WRITE/READ, bus_ack high in cycle M:
  - in cycle M+1 the strobe and busy go low, and the state returns to IDLE;
  - value_miso becomes {1, addr, wdata} for a write, or {1, addr, bus_rdata sampled in cycle M} for a read.
- WRITE/READ, no ack: the counter increments each strobe cycle. When TIMEOUT strobe cycles have elapsed without ack, the strobe drops, value_miso = {0, addr, 0}, and the state returns to IDLE. The strobe is high for exactly TIMEOUT cycles. An ack arriving in the final counted cycle is a successful completion.
- bus_ack while IDLE: ignored.
- value_miso changes only in the completion cycle and is otherwise stable. The SPI slave samples it at chip-select start.
- value_valid while busy, including the completion cycle: frame dropped, overrun pulses one cycle, bus outputs unaffected.
- cs_stop in a cycle without value_valid: frame_error pulses one cycle, no bus operation. cs_stop coinciding with value_valid is a normal frame.
- Back-to-back frames: a value_valid in the cycle after completion, with state IDLE, is accepted.

Optional Feature:
- Macro: SPI_REGISTER_BRIDGE_AUTOINC_EN.
- Defined:
  - an internal pointer (ADDR_WIDTH bits, reset 0) is loaded with (address of each completed operation)+1, wrapping modulo 2^ADDR_WIDTH; this applies on both ok and timeout;
  - frames whose address field is all-ones use the pointer as bus_addr instead;
  - the response address field reports the address actually used.
- Undefined: all-ones is an ordinary address, and no pointer exists.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=16, WIDTH=21):
1. Write: value_mosi=0x13BEEF pulsed; bus_ack 2 cycles after bus_we rises → bus_we=1 with bus_addr=3, bus_wdata=0xBEEF from the next cycle; bus_we held 2 cycles, low the cycle after ack; value_miso=0x13BEEF.
2. Read: value_mosi=0x050000; ack with bus_rdata=0x1234 → bus_re=1, bus_addr=5; value_miso=0x151234; busy low one cycle after ack.
3. Timeout, TIMEOUT=8: read of address 5, no ack → bus_re high exactly 8 cycles; value_miso=0x050000; a late ack afterwards is ignored.
4. Overrun: second value_valid (0x13AAAA) during a pending op → overrun pulses 1 cycle; bus_addr/bus_wdata unchanged; only the first op completes.
5. cs_stop without value_valid → frame_error pulses 1 cycle; no strobe. With the macro defined: write address 0xE acked, then read address 0xF acked → second bus_addr=0xF; value_miso address field 0xF.
6. reset asserted mid-READ → bus_re, busy, value_miso go 0 immediately; after release, a new read of address 2 completes normally.
